mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 36 +++
 rtl/mult_div_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU package: multiply/divide opcodes, default latencies and FSM encoding.
package mult_div_unit_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MFHI  = 4'd4,
        MD_MFLO  = 4'd5,
        MD_MTHI  = 4'd6,
        MD_MTLO  = 4'd7,
        MD_MADD  = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_long_op(input logic [3:0] op);
        return is_mult_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: results are computed at acceptance, held in a pending
// register, and committed to HI/LO on the last busy edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_state_e        state;
    md_state_e        state_next;
    logic [CNT_W-1:0] count;
    logic [63:0]      pending;

    logic        accept;
    logic        long_accept;
    logic        start_long;
    logic        done;
    logic        signed_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] result;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign accept      = start && (state == ST_IDLE);
    assign start_long  = start && is_long_op(md_op);
    assign long_accept = accept && is_long_op(md_op);
    assign done        = (state == ST_BUSY) && (count == '0);
    assign stall       = d_md && (busy || start_long);

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
    always_comb begin
        // NOTE: combinational block uses blocking assignments and sets every output first, so no latch is inferred.
        prod_s     = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
        prod_u     = {32'b0, op_a} * {32'b0, op_b};
        signed_div = (md_op == MD_DIV);
        mag_a      = (signed_div && op_a[31]) ? -op_a : op_a;
        mag_b      = (signed_div && op_b[31]) ? -op_b : op_b;
        divisor    = (op_b == '0) ? 32'd1 : mag_b;
        q_mag      = mag_a / divisor;
        r_mag      = mag_a % divisor;
        quot       = (signed_div && (op_a[31] ^ op_b[31])) ? -q_mag : q_mag;
        rem        = (signed_div && op_a[31]) ? -r_mag : r_mag;
        result     = {hi, lo};
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_DIV, MD_DIVU: begin
                // Divide by zero commits the current HI/LO, leaving them unchanged.
                if (op_b != '0) result = {rem, quot};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (long_accept) state_next = ST_BUSY;
            ST_BUSY: if (count == '0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_BUSY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (long_accept) begin
            count <= is_mult_op(md_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
        end else if ((state == ST_BUSY) && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         pending <= '0;
        else if (long_accept) pending <= result;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi <= '0;
            lo <= '0;
        end else if (done) begin
            {hi, lo} <= pending;
        end else if (accept && (md_op == MD_MTHI)) begin
            hi <= op_a;
        end else if (accept && (md_op == MD_MTLO)) begin
            lo <= op_a;
        end
    end

endmodule
